// File: rtl/tdm_demux4_if.sv
// Bus bundle for the four-slot TDM demultiplexer: serial beat stream in,
// four channel hold registers plus status strobes out.
interface tdm_demux4_if #(
  parameter int W = 2
);
  logic [W-1:0] din;
  logic         din_vld;
  logic         frame_sync;
  logic [W-1:0] y0;
  logic [W-1:0] y1;
  logic [W-1:0] y2;
  logic [W-1:0] y3;
  logic [3:0]   ch_vld;
  logic [1:0]   sel;
  logic         locked;
  logic         frame_done;
  logic         sync_err;

  // Stream source / channel consumer side.
  modport master (
    output din, din_vld, frame_sync,
    input  y0, y1, y2, y3, ch_vld, sel, locked, frame_done, sync_err
  );

  // Demultiplexer side.
  modport slave (
    input  din, din_vld, frame_sync,
    output y0, y1, y2, y3, ch_vld, sel, locked, frame_done, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer. Hunts for a frame_sync-qualified beat, then
// steers consecutive valid beats into y0..y3 following the {s2,s1} slot order.
// Falls back to hunting after TIMEOUT consecutive idle cycles while locked.
module tdm_demux4 #(
  parameter int W       = 2,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux4_if.slave   bus
);

  // A zero TIMEOUT disables the idle counter but still needs a legal width.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value on which the next idle cycle completes the timeout.
  localparam int CNT_LAST_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_LAST_INT);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state;
  logic [W-1:0]  y_q [4];
  logic [3:0]    ch_vld_q;
  logic [1:0]    sel_q;
  logic          locked_q;
  logic          frame_done_q;
  logic          sync_err_q;
  logic [CW-1:0] idle_cnt;

  // Frame tracking FSM with all outputs registered alongside the state.
  // NOTE: every register here uses <= so all of them sample the same
  // pre-edge values; a blocking = would let later lines see updated sel_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      // NOTE: the channel hold registers are reset too, since downstream
      // logic is allowed to read y0..y3 before the first frame arrives.
      for (int k = 0; k < 4; k++) y_q[k] <= '0;
      ch_vld_q     <= '0;
      sel_q        <= '0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      idle_cnt     <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      ch_vld_q     <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;

      case (state)
        HUNT: begin
          idle_cnt <= '0;
          if (bus.din_vld && bus.frame_sync) begin
            y_q[0]   <= bus.din;
            ch_vld_q <= 4'b0001;
            sel_q    <= 2'd1;
            state    <= LOCKED;
            locked_q <= 1'b1;
          end
        end

        LOCKED: begin
          if (bus.din_vld) begin
            idle_cnt <= '0;
            if (bus.frame_sync) begin
              // Slot-0 capture; flagged as an error only when it cuts a frame short.
              y_q[0]     <= bus.din;
              ch_vld_q   <= 4'b0001;
              sel_q      <= 2'd1;
              sync_err_q <= (sel_q != 2'd0);
            end else begin
              y_q[sel_q]   <= bus.din;
              ch_vld_q     <= 4'b0001 << sel_q;
              sel_q        <= sel_q + 2'd1;
              frame_done_q <= (sel_q == 2'd3);
            end
          end else if (TIMEOUT != 0) begin
            if (idle_cnt == CNT_LAST) begin
              state    <= HUNT;
              locked_q <= 1'b0;
              sel_q    <= '0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + CW'(1);
            end
          end
        end

        default: begin
          state    <= HUNT;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.y0         = y_q[0];
  assign bus.y1         = y_q[1];
  assign bus.y2         = y_q[2];
  assign bus.y3         = y_q[3];
  assign bus.ch_vld     = ch_vld_q;
  assign bus.sel        = sel_q;
  assign bus.locked     = locked_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed testbench for tdm_demux4: reset, full frame, hunt discard,
// resync, idle timeout and a 4:1 mux loopback with gaps.
module tb_tdm_demux4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tdm_demux4_if #(.W(2)) bus ();

  tdm_demux4 #(.W(2), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sources of the 4:1 mux feeding the loopback scenario (a, b, c, d).
  logic [1:0] mux_in [4];

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic vld, input logic sync, input logic [1:0] d);
    @(negedge clk);
    bus.din_vld    = vld;
    bus.frame_sync = sync;
    bus.din        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.din_vld    = 1'b0;
    bus.frame_sync = 1'b0;
    bus.din        = 2'b00;
    rst_n          = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b1, 1'b1, 2'b11);
    chk1("pre_reset_locked", bus.locked, 1'b1);
    chk2("pre_reset_y0", bus.y0, 2'b11);
    // Assert reset between edges; outputs must clear without a clock.
    #2;
    rst_n = 1'b0;
    #1;
    chk2("reset_y0", bus.y0, 2'b00);
    chk4("reset_ch_vld", bus.ch_vld, 4'b0000);
    chk2("reset_sel", bus.sel, 2'b00);
    chk1("reset_locked", bus.locked, 1'b0);
    chk1("reset_frame_done", bus.frame_done, 1'b0);
    chk1("reset_sync_err", bus.sync_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_frame();
    do_reset();
    step(1'b1, 1'b1, 2'b00);
    chk4("frame_ch_vld0", bus.ch_vld, 4'b0001);
    chk2("frame_sel1", bus.sel, 2'b01);
    chk1("frame_locked", bus.locked, 1'b1);
    step(1'b1, 1'b0, 2'b01);
    chk4("frame_ch_vld1", bus.ch_vld, 4'b0010);
    step(1'b1, 1'b0, 2'b10);
    chk4("frame_ch_vld2", bus.ch_vld, 4'b0100);
    chk1("frame_done_early", bus.frame_done, 1'b0);
    step(1'b1, 1'b0, 2'b11);
    chk4("frame_ch_vld3", bus.ch_vld, 4'b1000);
    chk1("frame_done", bus.frame_done, 1'b1);
    chk2("frame_sel_wrap", bus.sel, 2'b00);
    chk2("frame_y0", bus.y0, 2'b00);
    chk2("frame_y1", bus.y1, 2'b01);
    chk2("frame_y2", bus.y2, 2'b10);
    chk2("frame_y3", bus.y3, 2'b11);
    idle(1);
    chk1("frame_done_pulse", bus.frame_done, 1'b0);
    chk4("frame_ch_vld_idle", bus.ch_vld, 4'b0000);
    // Sync exactly at slot 0 is a normal start, not an error.
    step(1'b1, 1'b1, 2'b10);
    chk1("slot0_sync_no_err", bus.sync_err, 1'b0);
    chk2("slot0_sync_y0", bus.y0, 2'b10);
    chk2("slot0_sync_y3_hold", bus.y3, 2'b11);
  endtask

  task automatic test_hunt_discard();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 2'b01);
      chk4("hunt_no_strobe", bus.ch_vld, 4'b0000);
      chk1("hunt_unlocked", bus.locked, 1'b0);
    end
    chk2("hunt_y1_untouched", bus.y1, 2'b00);
    // frame_sync without din_vld is ignored.
    step(1'b0, 1'b1, 2'b11);
    chk1("hunt_sync_no_vld", bus.locked, 1'b0);
    step(1'b1, 1'b1, 2'b10);
    chk2("hunt_y0", bus.y0, 2'b10);
    chk1("hunt_locked", bus.locked, 1'b1);
    chk4("hunt_ch_vld", bus.ch_vld, 4'b0001);
  endtask

  task automatic test_resync();
    do_reset();
    step(1'b1, 1'b1, 2'b00);
    step(1'b1, 1'b0, 2'b01);
    step(1'b1, 1'b0, 2'b10);
    chk2("resync_sel_before", bus.sel, 2'b11);
    step(1'b1, 1'b1, 2'b11);
    chk1("resync_err", bus.sync_err, 1'b1);
    chk2("resync_y0", bus.y0, 2'b11);
    chk2("resync_sel", bus.sel, 2'b01);
    chk2("resync_y2_hold", bus.y2, 2'b10);
    chk1("resync_no_done", bus.frame_done, 1'b0);
    chk4("resync_ch_vld", bus.ch_vld, 4'b0001);
    idle(1);
    chk1("resync_err_pulse", bus.sync_err, 1'b0);
  endtask

  task automatic test_timeout();
    do_reset();
    step(1'b1, 1'b1, 2'b00);
    idle(10);
    // A valid beat clears the idle count.
    step(1'b1, 1'b0, 2'b01);
    idle(15);
    chk1("timeout_15_locked", bus.locked, 1'b1);
    chk2("timeout_15_sel", bus.sel, 2'b10);
    idle(1);
    chk1("timeout_16_unlocked", bus.locked, 1'b0);
    chk2("timeout_16_sel", bus.sel, 2'b00);
    chk2("timeout_y1_hold", bus.y1, 2'b01);
    step(1'b1, 1'b0, 2'b11);
    chk4("timeout_hunt_discard", bus.ch_vld, 4'b0000);
  endtask

  // Loopback: din is the 4:1 mux output selected by the DUT's sel.
  task automatic lb_beat(input logic sync);
    @(negedge clk);
    bus.din_vld    = 1'b1;
    bus.frame_sync = sync;
    bus.din        = mux_in[bus.sel];
    @(posedge clk);
    #1;
  endtask

  task automatic test_loopback();
    logic done_seen;
    mux_in[0] = 2'b00;
    mux_in[1] = 2'b01;
    mux_in[2] = 2'b10;
    mux_in[3] = 2'b11;
    do_reset();
    lb_beat(1'b1);
    idle(2);
    lb_beat(1'b0);
    idle(1);
    lb_beat(1'b0);
    idle(3);
    lb_beat(1'b0);
    done_seen = bus.frame_done;
    chk1("loop_frame_done", done_seen, 1'b1);
    chk2("loop_y0", bus.y0, 2'b00);
    chk2("loop_y1", bus.y1, 2'b01);
    chk2("loop_y2", bus.y2, 2'b10);
    chk2("loop_y3", bus.y3, 2'b11);
    chk1("loop_locked", bus.locked, 1'b1);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.din        = 2'b00;
    bus.din_vld    = 1'b0;
    bus.frame_sync = 1'b0;
    test_reset();
    test_frame();
    test_hunt_discard();
    test_resync();
    test_timeout();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
